fiber_stream_source: RTL and testbench
======================================

FIBER_STREAM_SOURCE -- requirements
Module: fiber_stream_source

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 The block SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port fiber_start  input  1  one-cycle pulse that opens a new fiber.
REQ-005 The block SHALL have port wr_valid  input  1  upstream coordinate valid.
REQ-006 The block SHALL have port wr_coord  input  64  upstream coordinate.
REQ-007 The block SHALL have port wr_last  input  1  qualifies wr_coord as final coordinate of the fiber.
REQ-008 The block SHALL have port wr_ready  output  1  write accepted when wr_valid&&wr_ready.
REQ-009 The block SHALL have port coord  output  64  head coordinate presented to a merger leaf input.
REQ-010 The block SHALL have port coord_valid  output  1  coord is meaningful.
REQ-011 The block SHALL have port fetch_next  input  1  merger pop request for the current coord.
REQ-012 The block SHALL have port done  output  1  fiber exhausted; coord holds sentinel.
REQ-013 The block SHALL have port pop_count  output  32  coordinates popped in the current fiber.
REQ-014 The block SHALL have port underflow_err  output  1  sticky; fetch_next seen while coord_valid=0.
REQ-015 The block SHALL have port order_err  output  1  sticky; non-increasing coordinate written.

Function
REQ-016 States SHALL be IDLE, STREAM, DONE.
REQ-017 IDLE: wr_ready=0, coord_valid=0, done=0; fiber_start -> STREAM, clearing pop_count.
REQ-018 STREAM: wr_ready = not full and wr_last not yet accepted in this fiber.
REQ-019 FIFO SHALL be show-ahead: coord = head entry, coord_valid = not empty; a write accepted in cycle N appears on coord in cycle N+1 when the FIFO was empty.
REQ-020 Pop occurs when fetch_next && coord_valid && state==STREAM; pop_count increments by 1, saturating at 32'hFFFF_FFFF.
REQ-021 Simultaneous accepted write and pop SHALL both take effect; occupancy unchanged.
REQ-022 Pop of the entry written with wr_last SHALL move STREAM -> DONE in the next cycle.
REQ-023 DONE: coord=64'hFFFF_FFFF_FFFF_FFFF, coord_valid=1, done=1, wr_ready=0; fetch_next ignored (sentinel never consumed).
REQ-024 fiber_start in DONE SHALL go to STREAM with empty FIFO and pop_count=0; fiber_start in STREAM SHALL be ignored.
REQ-025 fetch_next with coord_valid=0 in IDLE or STREAM SHALL set underflow_err and change no other state.
REQ-026 Sticky errors SHALL clear only on reset.

Reset
REQ-027 Assertion of reset SHALL immediately force: state IDLE, FIFO empty, coord=0, coord_valid=0, wr_ready=0, done=0, pop_count=0, underflow_err=0, order_err=0.
REQ-028 Reset asserted mid-fiber SHALL discard all buffered coordinates; first post-reset activity requires fiber_start.

Configuration
REQ-029 With FIBER_SRC_ORDER_CHECK_EN defined, each accepted write whose wr_coord is not strictly greater than the previous accepted write in the same fiber SHALL set order_err; the write is still stored.
REQ-030 Without FIBER_SRC_ORDER_CHECK_EN, order_err SHALL be constant 0 and no comparator state SHALL exist.

Verification
REQ-031 reset low then high, no stimulus -> coord_valid=0, wr_ready=0, done=0, all errors 0.
REQ-032 fiber_start; write 5, 9, 12(last); fetch_next held high -> coord sequence 5,9,12, pop_count=3, then done=1, coord=all-ones, coord_valid=1.
REQ-033 DEPTH=8; write 8 coordinates without pops -> wr_ready=0 on cycle after 8th; one pop -> wr_ready=1 next cycle; write+pop same cycle at occupancy 4 -> occupancy stays 4.
REQ-034 fiber_start; fetch_next with FIFO empty -> underflow_err=1, pop_count=0; stays 1 through second fiber.
REQ-035 Macro defined: write 7 then 7 -> order_err=1; macro undefined, same stimulus -> order_err=0, both coords popped.
REQ-036 Reset asserted after 2 of 4 writes -> FIFO empty, state IDLE; writes ignored until fiber_start.

Source files
------------

// File: rtl/fiber_stream_source_if.sv
// Leaf-source handshake bundle: upstream coordinate write channel plus the
// show-ahead coordinate port consumed by a merger leaf input.
interface fiber_stream_source_if;
    logic        wr_valid;
    logic [63:0] wr_coord;
    logic        wr_last;
    logic        wr_ready;
    logic [63:0] coord;
    logic        coord_valid;
    logic        fetch_next;
    logic        done;

    modport master (
        output wr_valid, wr_coord, wr_last, fetch_next,
        input  wr_ready, coord, coord_valid, done
    );

    modport slave (
        input  wr_valid, wr_coord, wr_last, fetch_next,
        output wr_ready, coord, coord_valid, done
    );
endinterface

// File: rtl/fiber_stream_source.sv
// Fiber coordinate source: show-ahead FIFO feeding one merger leaf, with an
// all-ones sentinel once the fiber is drained. Optional macro FIBER_SRC_ORDER_CHECK_EN.
module fiber_stream_source #(
    parameter int DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fiber_start,
    fiber_stream_source_if.slave        bus,
    output logic [31:0]                 pop_count,
    output logic                        underflow_err,
    output logic                        order_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              DATA_W   = 64;
    localparam logic [DATA_W-1:0] SENTINEL = '1;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state;
    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              last_seen;

    logic              fifo_empty;
    logic              fifo_full;
    logic              wr_open;
    logic              show_valid;
    logic              wr_fire;
    logic              pop_fire;
    logic              head_last;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign head_last  = mem[rd_ptr][DATA_W];

    // Once the final coordinate is in, the fiber is closed to further writes.
    assign wr_open    = (state == STREAM) && !fifo_full && !last_seen;
    assign show_valid = (state == DONE) || ((state == STREAM) && !fifo_empty);
    assign wr_fire    = bus.wr_valid && wr_open;
    assign pop_fire   = bus.fetch_next && (state == STREAM) && !fifo_empty;

    assign bus.wr_ready    = wr_open;
    assign bus.coord_valid = show_valid;
    assign bus.done        = (state == DONE);

    always_comb begin
        bus.coord = '0;
        if (state == DONE)
            bus.coord = SENTINEL;
        else if ((state == STREAM) && !fifo_empty)
            bus.coord = mem[rd_ptr][DATA_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (wr_fire)
            mem[wr_ptr] <= {bus.wr_last, bus.wr_coord};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            last_seen     <= 1'b0;
            pop_count     <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (bus.fetch_next && !show_valid)
                underflow_err <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (fiber_start) begin
                        state     <= STREAM;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        count     <= '0;
                        last_seen <= 1'b0;
                        pop_count <= '0;
                    end
                end
                STREAM: begin
                    if (wr_fire) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (bus.wr_last)
                            last_seen <= 1'b1;
                    end
                    // Popping the tagged final entry leaves the FIFO empty, so DONE follows directly.
                    if (pop_fire) begin
                        rd_ptr    <= rd_ptr + AW'(1);
                        pop_count <= sat_inc(pop_count);
                        if (head_last)
                            state <= DONE;
                    end
                    case ({wr_fire, pop_fire})
                        2'b10:   count <= count + (AW+1)'(1);
                        2'b01:   count <= count - (AW+1)'(1);
                        default: count <= count;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIBER_SRC_ORDER_CHECK_EN
    logic [DATA_W-1:0] prev_coord;
    logic              have_prev;

    always_ff @(posedge clock) begin
        if (wr_fire)
            prev_coord <= bus.wr_coord;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            have_prev <= 1'b0;
            order_err <= 1'b0;
        end else if (fiber_start && (state != STREAM)) begin
            have_prev <= 1'b0;
        end else if (wr_fire) begin
            have_prev <= 1'b1;
            if (have_prev && (bus.wr_coord <= prev_coord))
                order_err <= 1'b1;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_fiber_stream_source.sv
// Directed bench for fiber_stream_source: queue-based reference model checked
// every cycle, plus literal expectations for the main scenarios.
module tb_fiber_stream_source;

    localparam int DEPTH = 8;
`ifdef FIBER_SRC_ORDER_CHECK_EN
    localparam bit ORDER_ON = 1'b1;
`else
    localparam bit ORDER_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fiber_start = 1'b0;
    logic [31:0] pop_count;
    logic        underflow_err;
    logic        order_err;

    fiber_stream_source_if bus();

    fiber_stream_source #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .fiber_start   (fiber_start),
        .bus           (bus),
        .pop_count     (pop_count),
        .underflow_err (underflow_err),
        .order_err     (order_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    logic [63:0] popped[$];

    // Reference model: 0 = idle, 1 = streaming, 2 = drained
    int          m_state = 0;
    logic [64:0] m_q[$];
    logic [31:0] m_pcnt = '0;
    bit          m_under = 1'b0;
    bit          m_order = 1'b0;
    bit          m_last_acc = 1'b0;
    bit          m_have_prev = 1'b0;
    logic [63:0] m_prev = '0;

    function automatic bit m_wr_ready();
        return (m_state == 1) && (m_q.size() < DEPTH) && !m_last_acc;
    endfunction

    function automatic bit m_cv();
        return (m_state == 2) || ((m_state == 1) && (m_q.size() > 0));
    endfunction

    function automatic logic [63:0] m_coord();
        if (m_state == 2) return 64'hFFFF_FFFF_FFFF_FFFF;
        if ((m_state == 1) && (m_q.size() > 0)) return m_q[0][63:0];
        return 64'd0;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_pcnt = '0;
        m_under = 1'b0;
        m_order = 1'b0;
        m_last_acc = 1'b0;
        m_have_prev = 1'b0;
    endtask

    task automatic model_step();
        bit cv, acc, pop;
        logic [64:0] h;
        cv  = m_cv();
        acc = bus.wr_valid && m_wr_ready();
        pop = bus.fetch_next && cv && (m_state == 1);
        if (bus.fetch_next && !cv) m_under = 1'b1;
        if (m_state != 1) begin
            if (fiber_start) begin
                m_state = 1;
                m_q.delete();
                m_pcnt = '0;
                m_last_acc = 1'b0;
                m_have_prev = 1'b0;
            end
        end else begin
            if (pop) begin
                h = m_q.pop_front();
                if (m_pcnt != 32'hFFFF_FFFF) m_pcnt = m_pcnt + 32'd1;
                if (h[64]) m_state = 2;
            end
            if (acc) begin
                if (ORDER_ON && m_have_prev && (bus.wr_coord <= m_prev)) m_order = 1'b1;
                m_prev = bus.wr_coord;
                m_have_prev = 1'b1;
                if (bus.wr_last) m_last_acc = 1'b1;
                m_q.push_back({bus.wr_last, bus.wr_coord});
            end
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chkb("m_wr_ready", bus.wr_ready, m_wr_ready());
            chkb("m_coord_valid", bus.coord_valid, m_cv());
            chkb("m_done", bus.done, m_state == 2);
            chk("m_pop_count", 64'(pop_count), 64'(m_pcnt));
            chkb("m_underflow", underflow_err, m_under);
            chkb("m_order", order_err, m_order);
            if ((m_state != 1) || (m_q.size() > 0))
                chk("m_coord", bus.coord, m_coord());
            if (reset && bus.fetch_next && bus.coord_valid && !bus.done)
                popped.push_back(bus.coord);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_coord = '0;
        bus.wr_last = 1'b0;
        bus.fetch_next = 1'b0;
        #3 reset = 1'b0;
        repeat (2) tick();
        cmp_en = 1'b1;
        chkb("rst_cv", bus.coord_valid, 1'b0);
        chk("rst_coord", bus.coord, 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        chkb("idle_cv", bus.coord_valid, 1'b0);
        chkb("idle_wr_ready", bus.wr_ready, 1'b0);
        chkb("idle_done", bus.done, 1'b0);
        chkb("idle_under", underflow_err, 1'b0);
        chkb("idle_order", order_err, 1'b0);

        // Fiber 1: 5, 9, 12(last) with concurrent pops
        fiber_start = 1'b1; tick(); fiber_start = 1'b0;
        chkb("f1_wr_ready", bus.wr_ready, 1'b1);
        bus.wr_valid = 1'b1; bus.wr_coord = 64'd5; tick();
        chk("f1_head", bus.coord, 64'd5);
        bus.wr_coord = 64'd9; bus.fetch_next = 1'b1; tick();
        bus.wr_coord = 64'd12; bus.wr_last = 1'b1; tick();
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0; tick();
        chk("f1_pcnt", 64'(pop_count), 64'd3);
        chkb("f1_done", bus.done, 1'b1);
        chk("f1_sentinel", bus.coord, 64'hFFFF_FFFF_FFFF_FFFF);
        chkb("f1_cv", bus.coord_valid, 1'b1);
        tick();
        bus.fetch_next = 1'b0;
        chk("f1_pcnt_hold", 64'(pop_count), 64'd3);
        chk("f1_npop", 64'(popped.size()), 64'd3);
        chk("f1_seq0", (popped.size() > 0) ? popped[0] : '1, 64'd5);
        chk("f1_seq1", (popped.size() > 1) ? popped[1] : '1, 64'd9);
        chk("f1_seq2", (popped.size() > 2) ? popped[2] : '1, 64'd12);
        chkb("f1_under", underflow_err, 1'b0);
        popped.delete();

        // Fiber 2: fill to DEPTH, single pop, write+pop at occupancy 4
        fiber_start = 1'b1; tick(); fiber_start = 1'b0;
        chk("f2_pcnt0", 64'(pop_count), 64'd0);
        chkb("f2_cv0", bus.coord_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 1'b1; bus.wr_coord = 64'((i + 1) * 10); tick();
        end
        bus.wr_valid = 1'b0;
        chkb("f2_full", bus.wr_ready, 1'b0);
        chk("f2_head", bus.coord, 64'd10);
        bus.fetch_next = 1'b1; tick(); bus.fetch_next = 1'b0;
        chkb("f2_reopen", bus.wr_ready, 1'b1);
        chk("f2_head2", bus.coord, 64'd20);
        bus.fetch_next = 1'b1; repeat (3) tick(); bus.fetch_next = 1'b0;
        chk("f2_head_occ4", bus.coord, 64'd50);
        bus.wr_valid = 1'b1; bus.wr_coord = 64'd90; bus.fetch_next = 1'b1; tick();
        bus.fetch_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_coord = 64'(100 + 10 * i); tick();
            chkb("f2_fill_ready", bus.wr_ready, i < 3);
        end
        bus.wr_valid = 1'b0;
        chk("f2_head3", bus.coord, 64'd60);
        bus.fetch_next = 1'b1; tick(); bus.fetch_next = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_coord = 64'd140; bus.wr_last = 1'b1; tick();
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        chkb("f2_closed", bus.wr_ready, 1'b0);
        bus.fetch_next = 1'b1;
        for (int k = 0; k < 20 && !bus.done; k++) tick();
        bus.fetch_next = 1'b0;
        chkb("f2_done", bus.done, 1'b1);
        chk("f2_pcnt", 64'(pop_count), 64'd14);
        chk("f2_npop", 64'(popped.size()), 64'd14);
        for (int i = 0; i < 14; i++)
            chk("f2_seq", (i < popped.size()) ? popped[i] : '1, 64'((i + 1) * 10));
        popped.delete();

        // Fiber 3: underflow, duplicate coordinate, ignored fiber_start
        fiber_start = 1'b1; tick(); fiber_start = 1'b0;
        bus.fetch_next = 1'b1; tick(); bus.fetch_next = 1'b0;
        chkb("f3_under", underflow_err, 1'b1);
        chk("f3_pcnt", 64'(pop_count), 64'd0);
        chkb("f3_cv", bus.coord_valid, 1'b0);
        bus.wr_valid = 1'b1; bus.wr_coord = 64'd7; tick();
        bus.wr_last = 1'b1; fiber_start = 1'b1; tick();
        fiber_start = 1'b0; bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        chkb("f3_order", order_err, ORDER_ON);
        chk("f3_head", bus.coord, 64'd7);
        bus.fetch_next = 1'b1; repeat (2) tick(); bus.fetch_next = 1'b0;
        chkb("f3_done", bus.done, 1'b1);
        chk("f3_pcnt2", 64'(pop_count), 64'd2);
        chk("f3_npop", 64'(popped.size()), 64'd2);
        chk("f3_seq0", (popped.size() > 0) ? popped[0] : '1, 64'd7);
        chk("f3_seq1", (popped.size() > 1) ? popped[1] : '1, 64'd7);
        popped.delete();
        fiber_start = 1'b1; tick(); fiber_start = 1'b0;
        chkb("f4_under_sticky", underflow_err, 1'b1);
        chk("f4_pcnt", 64'(pop_count), 64'd0);
        chkb("f4_order_sticky", order_err, ORDER_ON);

        // Reset mid-fiber after 2 of 4 writes
        bus.wr_valid = 1'b1; bus.wr_coord = 64'd1; tick();
        bus.wr_coord = 64'd2; tick();
        bus.wr_coord = 64'd3;
        #1 reset = 1'b0;
        #1;
        chkb("mr_cv", bus.coord_valid, 1'b0);
        chkb("mr_wr_ready", bus.wr_ready, 1'b0);
        chk("mr_coord", bus.coord, 64'd0);
        chkb("mr_done", bus.done, 1'b0);
        chk("mr_pcnt", 64'(pop_count), 64'd0);
        chkb("mr_under", underflow_err, 1'b0);
        chkb("mr_order", order_err, 1'b0);
        tick();
        reset = 1'b1;
        bus.wr_coord = 64'd4; tick(); tick();
        bus.wr_valid = 1'b0;
        chkb("pr_cv", bus.coord_valid, 1'b0);
        chkb("pr_wr_ready", bus.wr_ready, 1'b0);
        fiber_start = 1'b1; tick(); fiber_start = 1'b0;
        chkb("pr_empty", bus.coord_valid, 1'b0);
        chkb("pr_open", bus.wr_ready, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
